program_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the core's instruction memory. It receives a program image over a UART serial line, assembles little-endian 32-bit words and writes them into instruction memory through its write port. It holds the core in reset until a complete, checksum-verified image has been written, then releases the core to fetch from PC 0.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/program_loader_uart_rx.sv | 95 +++++++++
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader and its UART receiver.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] LOADER_MAGIC    = 8'hA5;

    // 8N1 framing: one start bit, eight data bits LSB first, no parity, one stop bit
    localparam int         UART_DATA_BITS  = 8;
    localparam logic       UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start re-check at mid-bit, LSB-first sampling.
// Latency: byte_valid/frame_err pulse one cycle after the stop-bit sample.
// Backpressure: none; the line cannot be stalled, so each byte is presented exactly once.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx,
    output logic                      byte_valid,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      frame_err
);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int                IDX_W     = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    logic                      sync1;
    logic                      sync2;
    logic                      sync_d;
    rx_state_t                 rstate;
    logic [CNT_W-1:0]          clk_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= UART_IDLE_LEVEL;
            sync2      <= UART_IDLE_LEVEL;
            sync_d     <= UART_IDLE_LEVEL;
            rstate     <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx;
            sync2      <= sync1;
            sync_d     <= sync2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rstate)
                RX_IDLE: begin
                    if (sync_d && !sync2) begin
                        rstate  <= RX_START;
                        clk_cnt <= '0;
                    end
                end
                RX_START: begin
                    // a start bit that is already high again at mid-bit was a glitch
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        rstate  <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {sync2, shreg[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            rstate <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        rstate  <= RX_IDLE;
                        if (sync2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives an A5 / N / N words (LSB first) / XOR frame and writes it into imem.
// Latency: imem write one cycle after a word's 4th byte; release one cycle after a good checksum.
// Backpressure: none; every received byte is consumed on arrival, core held in reset meanwhile.
module program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 7,
    parameter int TIMEOUT_CLKS = 1048576
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [31:0]           imem_data,
    output logic                  imem_wren,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error
);
    localparam int                CNT_W     = ADDR_WIDTH + 1;
    localparam int unsigned       MAX_WORDS = 1 << ADDR_WIDTH;
    localparam int                TMO_W     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err;
    loader_state_t    state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_index;
    logic [1:0]       byte_index;
    logic [23:0]      word_buf;
    logic [7:0]       csum;
    logic [TMO_W-1:0] idle_cnt;
    logic             active;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign active = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            word_index   <= '0;
            byte_index   <= '0;
            word_buf     <= '0;
            csum         <= '0;
            idle_cnt     <= '0;
            imem_address <= '0;
            imem_data    <= '0;
            imem_wren    <= 1'b0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            imem_wren <= 1'b0;
            if (byte_valid) begin
                // idle_cnt holds cycles since the last byte, counting that byte's cycle
                idle_cnt <= TMO_W'(1);
                case (state)
                    ST_IDLE: begin
                        if (byte_data == LOADER_MAGIC) begin
                            state <= ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (byte_data == 8'd0 || 32'(byte_data) > MAX_WORDS) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end else begin
                            count      <= CNT_W'(byte_data);
                            word_index <= '0;
                            byte_index <= '0;
                            csum       <= '0;
                            state      <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        csum       <= csum ^ byte_data;
                        byte_index <= byte_index + 2'd1;
                        case (byte_index)
                            2'd0:    word_buf[7:0]   <= byte_data;
                            2'd1:    word_buf[15:8]  <= byte_data;
                            2'd2:    word_buf[23:16] <= byte_data;
                            default: begin
                                imem_address <= word_index[ADDR_WIDTH-1:0];
                                imem_data    <= {byte_data, word_buf};
                                imem_wren    <= 1'b1;
                                word_index   <= word_index + CNT_W'(1);
                                if (word_index + CNT_W'(1) == count) begin
                                    state <= ST_CHECK;
                                end
                            end
                        endcase
                    end
                    ST_CHECK: begin
                        if (byte_data == csum) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                    ST_ERROR: begin
                        if (byte_data == LOADER_MAGIC) begin
                            state <= ST_COUNT;
                            error <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (active && (frame_err || idle_cnt == TMO_LAST)) begin
                state <= ST_ERROR;
                error <= 1'b1;
            end else if (active) begin
                idle_cnt <= idle_cnt + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames checked against a queue-based model of the frame rules.
module tb_program_loader;
    localparam int CPB = 4;
    localparam int TMO = 200;
    localparam int AW  = 7;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          uart_rx = 1'b1;
    logic [AW-1:0] imem_address;
    logic [31:0]   imem_data;
    logic          imem_wren;
    logic          core_reset;
    logic          done;
    logic          error;

    program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .imem_address(imem_address),
        .imem_data   (imem_data),
        .imem_wren   (imem_wren),
        .core_reset  (core_reset),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int          tag;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } wr_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         bv_cyc[$];
    logic [7:0] bv_dat[$];
    wr_t        got_wr[$];
    int         done_rise = -1;
    int         err_rise  = -1;
    int         err_fall  = -1;
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;

    wr_t        exp_wr[$];
    logic       exp_done;
    logic       exp_err;
    int         exp_done_pos;
    logic       cur_err = 1'b0;

    // Monitor: samples on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clock);
        cyc++;
        if (dut.u_rx.byte_valid) begin
            bv_cyc.push_back(cyc);
            bv_dat.push_back(dut.u_rx.byte_data);
        end
        if (imem_wren) got_wr.push_back('{cyc, imem_address, imem_data});
        if (done && !prev_done) done_rise = cyc;
        if (error && !prev_err) err_rise = cyc;
        if (!error && prev_err) err_fall = cyc;
        prev_done = done;
        prev_err  = error;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [10:0] bits;
        bits = {1'b1, stop, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            uart_rx = bits[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clock);
        reset   = 1'b0;
        @(negedge clock);
        cur_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":core_reset"}, 64'(core_reset), 64'(1));
        check({tag, ":done"},       64'(done),       64'(0));
        check({tag, ":error"},      64'(error),      64'(0));
        check({tag, ":wren"},       64'(imem_wren),  64'(0));
        check({tag, ":addr"},       64'(imem_address), 64'(0));
        check({tag, ":data"},       64'(imem_data),  64'(0));
    endtask

    // Frame rules over a byte stream: hunt magic, validate count, collect words, compare XOR.
    task automatic model(input byte_q_t b, input logic start_err);
        int         i;
        int         n;
        int         got;
        logic [7:0] x;
        i = 0;
        exp_wr = {};
        exp_done = 1'b0;
        exp_err = start_err;
        exp_done_pos = -1;
        while (i < b.size() && !exp_done) begin
            if (b[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            exp_err = 1'b0;
            if (i >= b.size()) break;
            n = int'(b[i]);
            i++;
            if (n < 1 || n > (1 << AW)) begin
                exp_err = 1'b1;
                continue;
            end
            x = 8'h00;
            got = 0;
            while (got < n && i + 3 < b.size()) begin
                exp_wr.push_back('{i + 3, AW'(got), {b[i+3], b[i+2], b[i+1], b[i]}});
                x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
                got++;
                i += 4;
            end
            if (got < n || i >= b.size()) break;
            exp_done = (b[i] == x);
            exp_err  = !exp_done;
            if (exp_done) exp_done_pos = i;
            i++;
        end
    endtask

    task automatic run_frame(input string tag, input byte_q_t b);
        int bv0;
        int wr0;
        int nw;
        bv0 = bv_cyc.size();
        wr0 = got_wr.size();
        model(b, cur_err);
        foreach (b[i]) send_byte(b[i], 1'b1);
        repeat (20) @(negedge clock);
        check({tag, ":nbytes"}, 64'(bv_cyc.size() - bv0), 64'(b.size()));
        if (bv_cyc.size() - bv0 == b.size()) begin
            foreach (b[i]) check({tag, ":rxbyte"}, 64'(bv_dat[bv0 + i]), 64'(b[i]));
        end
        nw = got_wr.size() - wr0;
        check({tag, ":nwrites"}, 64'(nw), 64'(exp_wr.size()));
        for (int k = 0; k < nw && k < exp_wr.size(); k++) begin
            check({tag, ":wr_addr"}, 64'(got_wr[wr0 + k].addr), 64'(exp_wr[k].addr));
            check({tag, ":wr_data"}, 64'(got_wr[wr0 + k].data), 64'(exp_wr[k].data));
            if (bv0 + exp_wr[k].tag < bv_cyc.size())
                check({tag, ":wr_cyc"}, 64'(got_wr[wr0 + k].tag),
                      64'(bv_cyc[bv0 + exp_wr[k].tag] + 1));
        end
        check({tag, ":done"},       64'(done),       64'(exp_done));
        check({tag, ":error"},      64'(error),      64'(exp_err));
        check({tag, ":core_reset"}, 64'(core_reset), 64'(!exp_done));
        if (exp_done && bv0 + exp_done_pos < bv_cyc.size())
            check({tag, ":done_cyc"}, 64'(done_rise), 64'(bv_cyc[bv0 + exp_done_pos] + 1));
        cur_err = exp_err;
    endtask

    byte_q_t    good;
    byte_q_t    bad;
    byte_q_t    f;
    int         b0;
    int         n;
    logic [7:0] x;
    logic [7:0] v;

    initial begin
        good = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        bad  = good;
        bad[10] = 8'h91;

        do_reset();
        check_reset_outputs("reset");

        run_frame("good", good);
        check("good:last_wr_gap", 64'((done_rise - got_wr[got_wr.size()-1].tag) >= 8 * CPB), 64'(1));

        do_reset();
        run_frame("badsum", bad);
        b0 = bv_cyc.size();
        run_frame("retry", good);
        check("retry:err_fall_cyc", 64'(err_fall), 64'(bv_cyc[b0] + 1));

        do_reset();
        run_frame("count0", '{8'hA5, 8'h00});
        run_frame("count129", '{8'hA5, 8'h81});
        run_frame("count128_hdr", '{8'hA5, 8'h80});

        do_reset();
        run_frame("noise", '{8'h55});
        b0 = bv_cyc.size();
        send_byte(8'h3C, 1'b0);
        repeat (10) @(negedge clock);
        check("idle_ferr:error", 64'(error), 64'(0));
        check("idle_ferr:nbytes", 64'(bv_cyc.size() - b0), 64'(0));
        run_frame("ferr_hdr", '{8'hA5});
        send_byte(8'h3C, 1'b0);
        repeat (10) @(negedge clock);
        check("active_ferr:error", 64'(error), 64'(1));
        check("active_ferr:done", 64'(done), 64'(0));

        do_reset();
        run_frame("tmo_hdr", '{8'hA5, 8'h01, 8'h13});
        for (int k = 0; k < 300 && !error; k++) @(negedge clock);
        check("timeout:error", 64'(error), 64'(1));
        check("timeout:cyc", 64'(err_rise - bv_cyc[bv_cyc.size()-1]), 64'(TMO));

        do_reset();
        for (int i = 0; i < 6; i++) send_byte(good[i], 1'b1);
        repeat (5) @(negedge clock);
        do_reset();
        check_reset_outputs("midreset");
        run_frame("after_reset", good);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            f = {};
            if ($urandom_range(0, 1) == 1) f.push_back(8'($urandom_range(0, 164)));
            n = $urandom_range(1, 5);
            f.push_back(8'hA5);
            f.push_back(8'(n));
            x = 8'h00;
            for (int j = 0; j < 4 * n; j++) begin
                v = 8'($urandom);
                f.push_back(v);
                x = x ^ v;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            f.push_back(x);
            run_frame("rand", f);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
